// File: rtl/const_map_pkg.sv
// rtl/const_map_pkg.sv - shared widths, address map and FSM encoding for the constellation mapper
package const_map_pkg;

  localparam int NCARR_DEF  = 256;
  localparam int DW_DEF     = 8;
  localparam int MAXB_DEF   = 15;
  localparam int CONSTW_DEF = 9;

  localparam int CNUMW_DEF  = $clog2(NCARR_DEF);
  localparam int CONFAW_DEF = $clog2(2 * NCARR_DEF + 2);
  localparam int BW_DEF     = $clog2(MAXB_DEF + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EMIT  = 2'd2
  } state_e;

  // Bit-loading table sits at 0, carrier-number table at ncarr, then two scalars.
  function automatic int addr_used(input int ncarr);
    return 2 * ncarr;
  endfunction

  function automatic int addr_fast(input int ncarr);
    return 2 * ncarr + 1;
  endfunction

endpackage

// File: rtl/bit_accum.sv
// rtl/bit_accum.sv - LSB-first bit accumulator: byte append above held bits, pop of the b lowest bits
module bit_accum #(
  parameter int DW   = 8,
  parameter int MAXB = 15,
  parameter int BW   = 4,
  parameter int AW   = MAXB + DW - 1,
  parameter int CW   = $clog2(AW + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr_i,
  input  logic            push_i,
  input  logic [DW-1:0]   push_data_i,
  input  logic            pop_i,
  input  logic [BW-1:0]   pop_b_i,
  output logic [CW-1:0]   count_o,
  output logic [MAXB-1:0] bits_o
);

  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (push_i) begin
      acc_d = acc_q | (AW'(push_data_i) << cnt_q);
      cnt_d = cnt_q + CW'(DW);
    end else if (pop_i) begin
      acc_d = acc_q >> pop_b_i;
      cnt_d = cnt_q - CW'(pop_b_i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;
  assign bits_o  = acc_q[MAXB-1:0];

endmodule

// File: rtl/const_map_engine.sv
// rtl/const_map_engine.sv - DMT constellation mapper: pulls bits per tone from fast/interleaved bytes, emits X/Y
module const_map_engine
  import const_map_pkg::*;
#(
  parameter int NCARR    = NCARR_DEF,
  parameter int DW       = DW_DEF,
  parameter int MAXB     = MAXB_DEF,
  parameter int CONSTW   = CONSTW_DEF,
  localparam int CNUMW   = $clog2(NCARR),
  localparam int CONFAW  = $clog2(2 * NCARR + 2),
  localparam int BW      = $clog2(MAXB + 1),
  localparam int ACW     = $clog2(MAXB + DW)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fast_valid_i,
  output logic              fast_ready_o,
  input  logic [DW-1:0]     fast_data_i,
  input  logic              inter_valid_i,
  output logic              inter_ready_o,
  input  logic [DW-1:0]     inter_data_i,
  input  logic              we_conf_i,
  input  logic [CONFAW-1:0] addr_i,
  input  logic [CNUMW-1:0]  conf_data_i,
  input  logic              sym_start_i,
  output logic              busy_o,
  output logic              sym_done_o,
  output logic              cfg_err_o,
  output logic              xy_valid_o,
  input  logic              xy_ready_i,
  output logic [CNUMW-1:0]  carrier_num_o,
  output logic [CONSTW-1:0] x_o,
  output logic [CONSTW-1:0] y_o
);

  logic [BW-1:0]    bitload_mem [NCARR];
  logic [CNUMW-1:0] carrier_mem [NCARR];

  state_e            state_q, state_d;
  logic [CNUMW-1:0]  used_q, used_d, fastb_q, fastb_d, fcnt_q, fcnt_d, k_q, k_d, cnum_q, cnum_d;
  logic [CONSTW-1:0] x_q, x_d, y_q, y_d, xm, ym;
  logic              done_q, done_d, err_q, err_d;
  logic [BW-1:0]     b_raw, b_eff;
  logic [ACW-1:0]    acc_cnt;
  logic [MAXB-1:0]   acc_bits, sx, sy;
  logic              need, use_fast, push, pop, clr, cfg_ok, cfg_bad;
  logic [DW-1:0]     push_data;
  logic [CNUMW:0]    k_next;
  logic [CNUMW-1:0]  carr_idx;
  int                px, py;

  assign busy_o   = (state_q != ST_IDLE);
  assign cfg_ok   = we_conf_i && !busy_o && (addr_i <= CONFAW'(addr_fast(NCARR)));
  assign cfg_bad  = we_conf_i && (busy_o || (addr_i > CONFAW'(addr_fast(NCARR))));
  assign carr_idx = CNUMW'(addr_i - CONFAW'(NCARR));

  always_ff @(posedge clk) begin
    if (cfg_ok && (addr_i < CONFAW'(NCARR)))
      bitload_mem[addr_i[CNUMW-1:0]] <= conf_data_i[BW-1:0];
    if (cfg_ok && (addr_i >= CONFAW'(NCARR)) && (addr_i < CONFAW'(addr_used(NCARR))))
      carrier_mem[carr_idx] <= conf_data_i;
  end

  // A one-bit tone cannot form a point, so it degrades to an empty tone.
  assign b_raw     = bitload_mem[k_q];
  assign b_eff     = (b_raw == BW'(1)) ? '0 : b_raw;
  assign need      = (acc_cnt < ACW'(b_eff));
  assign use_fast  = (fcnt_q < fastb_q);
  assign push_data = use_fast ? fast_data_i : inter_data_i;
  assign k_next    = {1'b0, k_q} + (CNUMW+1)'(1);

  bit_accum #(.DW(DW), .MAXB(MAXB), .BW(BW), .CW(ACW)) u_accum (
    .clk         (clk),
    .reset       (reset),
    .clr_i       (clr),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .pop_b_i     (b_eff),
    .count_o     (acc_cnt),
    .bits_o      (acc_bits)
  );

  // X takes v(b-1),v(b-3).. and Y v(b-2),v(b-4).. above a constant 1; clamping repeats the sign bit.
  always_comb begin
    xm = '0;
    ym = '0;
    px = 0;
    py = 0;
    sx = '0;
    sy = '0;
    if (b_eff != '0) begin
      xm[0] = 1'b1;
      ym[0] = 1'b1;
      for (int j = 1; j < CONSTW; j++) begin
        px = (b_eff[0] ? 0 : 1) + 2 * (j - 1);
        py = (b_eff[0] ? 1 : 0) + 2 * (j - 1);
        if (px > int'(b_eff) - 1) px = int'(b_eff) - 1;
        if (py > int'(b_eff) - 2) py = int'(b_eff) - 2;
        sx = acc_bits >> px;
        sy = acc_bits >> py;
        xm[j] = sx[0];
        ym[j] = sy[0];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    used_d        = used_q;
    fastb_d       = fastb_q;
    fcnt_d        = fcnt_q;
    k_d           = k_q;
    cnum_d        = cnum_q;
    x_d           = x_q;
    y_d           = y_q;
    done_d        = 1'b0;
    err_d         = err_q | cfg_bad;
    clr           = 1'b0;
    push          = 1'b0;
    pop           = 1'b0;
    fast_ready_o  = 1'b0;
    inter_ready_o = 1'b0;
    if (cfg_ok && (addr_i == CONFAW'(addr_used(NCARR)))) used_d  = conf_data_i;
    if (cfg_ok && (addr_i == CONFAW'(addr_fast(NCARR)))) fastb_d = conf_data_i;
    unique case (state_q)
      ST_IDLE: begin
        if (sym_start_i) begin
          if (used_q != '0) begin
            state_d = ST_FETCH;
            k_d     = '0;
            fcnt_d  = '0;
            clr     = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_FETCH: begin
        if (b_raw == BW'(1)) err_d = 1'b1;
        if (need) begin
          fast_ready_o  = use_fast;
          inter_ready_o = !use_fast;
          push          = use_fast ? fast_valid_i : inter_valid_i;
          if (push && use_fast) fcnt_d = fcnt_q + CNUMW'(1);
        end else begin
          state_d = ST_EMIT;
          x_d     = xm;
          y_d     = ym;
          cnum_d  = carrier_mem[k_q];
        end
      end
      ST_EMIT: begin
        if (xy_ready_i) begin
          pop = 1'b1;
          if (k_next < {1'b0, used_q}) begin
            k_d     = k_next[CNUMW-1:0];
            state_d = ST_FETCH;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      used_q  <= '0;
      fastb_q <= '0;
      fcnt_q  <= '0;
      k_q     <= '0;
      cnum_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      used_q  <= used_d;
      fastb_q <= fastb_d;
      fcnt_q  <= fcnt_d;
      k_q     <= k_d;
      cnum_q  <= cnum_d;
      x_q     <= x_d;
      y_q     <= y_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign xy_valid_o    = (state_q == ST_EMIT);
  assign sym_done_o    = done_q;
  assign cfg_err_o     = err_q;
  assign x_o           = x_q;
  assign y_o           = y_q;
  assign carrier_num_o = cnum_q;

endmodule

// File: tb/tb_const_map_engine.sv
// tb/tb_const_map_engine.sv - randomized scoreboard bench for const_map_engine
module tb_const_map_engine;

  typedef struct {
    logic [8:0] x;
    logic [8:0] y;
    logic [7:0] cn;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       fast_valid_i = 1'b0, inter_valid_i = 1'b0;
  logic [7:0] fast_data_i = '0, inter_data_i = '0;
  logic       fast_ready_o, inter_ready_o;
  logic       we_conf_i = 1'b0;
  logic [9:0] addr_i = '0;
  logic [7:0] conf_data_i = '0;
  logic       sym_start_i = 1'b0;
  logic       busy_o, sym_done_o, cfg_err_o, xy_valid_o;
  logic       xy_ready_i = 1'b0;
  logic [7:0] carrier_num_o;
  logic [8:0] x_o, y_o;

  int         checks = 0, errors = 0;
  exp_t       exp_q[$];
  logic [7:0] fast_q[$], inter_q[$], seed_q[$];
  int         m_bl[256];
  logic [7:0] m_cn[256];
  int         m_used = 0, m_fastb = 0;
  logic       m_err = 1'b0;
  int         hold_cycles = 0;
  logic       fast_rdy_seen = 1'b0;

  always #5 clk = ~clk;

  const_map_engine dut (
    .clk(clk), .reset(reset),
    .fast_valid_i(fast_valid_i), .fast_ready_o(fast_ready_o), .fast_data_i(fast_data_i),
    .inter_valid_i(inter_valid_i), .inter_ready_o(inter_ready_o), .inter_data_i(inter_data_i),
    .we_conf_i(we_conf_i), .addr_i(addr_i), .conf_data_i(conf_data_i),
    .sym_start_i(sym_start_i), .busy_o(busy_o), .sym_done_o(sym_done_o), .cfg_err_o(cfg_err_o),
    .xy_valid_o(xy_valid_o), .xy_ready_i(xy_ready_i),
    .carrier_num_o(carrier_num_o), .x_o(x_o), .y_o(y_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Point from the bit list {v[first], v[first-2], ..., 1}, read as a two's complement number.
  function automatic logic [8:0] pack(input int val, input int b, input int first);
    int r = 0, w = 0;
    if (b == 0) return 9'd0;
    for (int i = first; i >= 0; i -= 2) begin
      r = r * 2 + ((val >> i) & 1);
      w++;
    end
    r = r * 2 + 1;
    w++;
    if (r >= (1 << (w - 1))) r -= (1 << w);
    return 9'(r);
  endfunction

  // Source driver: presents queued bytes with random gaps, randomizes output backpressure.
  initial begin
    logic f_acc, i_acc;
    forever begin
      @(negedge clk);
      f_acc = fast_valid_i && fast_ready_o;
      i_acc = inter_valid_i && inter_ready_o;
      @(posedge clk);
      #1;
      if (f_acc && fast_q.size() > 0) void'(fast_q.pop_front());
      if (i_acc && inter_q.size() > 0) void'(inter_q.pop_front());
      fast_valid_i  = (fast_q.size() > 0) && ($urandom_range(3) != 0);
      fast_data_i   = (fast_q.size() > 0) ? fast_q[0] : 8'($urandom);
      inter_valid_i = (inter_q.size() > 0) && ($urandom_range(3) != 0);
      inter_data_i  = (inter_q.size() > 0) ? inter_q[0] : 8'($urandom);
      if (hold_cycles > 0 && xy_valid_o) begin
        xy_ready_i = 1'b0;
        hold_cycles--;
      end else begin
        xy_ready_i = ($urandom_range(3) != 0);
      end
    end
  end

  // Monitor: scoreboard compare on each accepted point, plus hold-stability while stalled.
  initial begin
    logic       stalled = 1'b0;
    logic [8:0] hx = '0, hy = '0;
    logic [7:0] hc = '0;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (fast_ready_o) fast_rdy_seen = 1'b1;
      if (stalled && xy_valid_o) begin
        chk("hold_xyc", {x_o, y_o, carrier_num_o}, {hx, hy, hc});
      end
      if (xy_valid_o && !xy_ready_i) begin
        stalled = 1'b1;
        hx = x_o;
        hy = y_o;
        hc = carrier_num_o;
        chk("stall_no_ready", {fast_ready_o, inter_ready_o}, 2'b00);
      end else begin
        stalled = 1'b0;
      end
      if (xy_valid_o && xy_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_point", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("x_o", x_o, e.x);
          chk("y_o", y_o, e.y);
          chk("carrier_num_o", carrier_num_o, e.cn);
        end
      end
    end
  end

  task automatic cfg_raw(input int addr, input int data);
    @(posedge clk);
    #1;
    we_conf_i   = 1'b1;
    addr_i      = 10'(addr);
    conf_data_i = 8'(data);
    @(posedge clk);
    #1;
    we_conf_i   = 1'b0;
  endtask

  task automatic cfg(input int addr, input int data);
    cfg_raw(addr, data);
    if (addr < 256) m_bl[addr] = data & 15;
    else if (addr < 512) m_cn[addr - 256] = 8'(data);
    else if (addr == 512) m_used = data;
    else if (addr == 513) m_fastb = data;
    else m_err = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_ready", {fast_ready_o, inter_ready_o, xy_valid_o}, 3'b000);
    chk("rst_flags", {busy_o, sym_done_o, cfg_err_o}, 3'b000);
    chk("rst_xyc", {x_o, y_o, carrier_num_o}, 26'd0);
    reset = 1'b0;
    m_err = 1'b0;
    m_used = 0;
    m_fastb = 0;
    exp_q.delete();
    fast_q.delete();
    inter_q.delete();
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1;
    sym_start_i = 1'b1;
    @(posedge clk);
    #1;
    sym_start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (sym_done_o) seen = 1;
    end
    chk("sym_done_seen", seen, 1);
  endtask

  // Reference: tones draw whole bytes (fast first up to FastBytes) only until b bits are held.
  task automatic run_symbol();
    bit         acc[$];
    int         ftaken = 0, be, val;
    logic [7:0] byt;
    exp_t       e;
    for (int k = 0; k < m_used; k++) begin
      be = (m_bl[k] == 1) ? 0 : m_bl[k];
      if (m_bl[k] == 1) m_err = 1'b1;
      while (acc.size() < be) begin
        byt = (seed_q.size() > 0) ? seed_q.pop_front() : 8'($urandom);
        if (ftaken < m_fastb) begin
          fast_q.push_back(byt);
          ftaken++;
        end else begin
          inter_q.push_back(byt);
        end
        for (int i = 0; i < 8; i++) acc.push_back(byt[i]);
      end
      val = 0;
      for (int i = 0; i < be; i++) val |= int'(acc.pop_front()) << i;
      e.x  = pack(val, be, be - 1);
      e.y  = pack(val, be, be - 2);
      e.cn = m_cn[k];
      exp_q.push_back(e);
    end
    pulse_start();
    wait_done(3000);
    chk("all_points_out", exp_q.size(), 0);
    chk("bytes_consumed", fast_q.size() + inter_q.size(), 0);
    chk("idle_after_done", busy_o, 0);
    chk("cfg_err_o", cfg_err_o, m_err);
  endtask

  task automatic setup(input int used, input int fastb);
    cfg(512, used);
    cfg(513, fastb);
  endtask

  initial begin
    do_reset();

    // Empty symbol: only a done pulse.
    pulse_start();
    chk("empty_not_busy", busy_o, 0);
    wait_done(3);

    cfg(0, 2); cfg(256, 8'h37); setup(1, 1);
    seed_q = '{8'h03};
    run_symbol();

    cfg(0, 4); cfg(256, 8'hC1); setup(1, 0);
    seed_q = '{8'hA5};
    run_symbol();

    cfg(0, 4); cfg(1, 4); cfg(257, 8'h55); setup(2, 0);
    seed_q = '{8'h5A};
    fast_rdy_seen = 1'b0;
    run_symbol();
    chk("fast_ready_never", fast_rdy_seen, 0);

    cfg(0, 6); cfg(1, 9); setup(2, 1);
    hold_cycles = 5;
    run_symbol();
    chk("hold_consumed", hold_cycles, 0);

    cfg(0, 1); cfg(1, 4); setup(2, 1);
    run_symbol();
    chk("b1_sets_err", cfg_err_o, 1);

    // Underflow stall, write while busy, then reset from FETCH.
    do_reset();
    cfg(0, 6); cfg(256, 8'h9E); setup(1, 0);
    pulse_start();
    repeat (5) @(posedge clk);
    #1;
    chk("stall_in_fetch", {busy_o, inter_ready_o, cfg_err_o}, 3'b110);
    cfg_raw(0, 4);
    chk("busy_write_err", cfg_err_o, 1);
    do_reset();
    setup(1, 1);
    run_symbol();

    cfg(1023, 0);
    chk("bad_addr_err", cfg_err_o, 1);

    do_reset();
    for (int s = 0; s < 20; s++) begin
      int used;
      used = $urandom_range(5, 1);
      for (int k = 0; k < used; k++) begin
        cfg(k, $urandom_range(15));
        cfg(256 + k, $urandom_range(255));
      end
      setup(used, $urandom_range(3));
      run_symbol();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
